serial_adder: RTL and testbench

Bit-serial adder that adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first. It uses a single instance of the team's 1-bit full adder cell `fa_dataflow` (ports `s`, `co`, `a`, `b`, `ci`), with a registered carry loop, two operand shift registers and a start/done handshake. It sits directly downstream of the full adder cell: it consumes the cell's `s` and `co` every cycle and feeds `co` back into `ci`.

---
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: {co,s} = a + b + ci, one bit per clock, LSB first, through one fa_dataflow cell.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output `ovf`.

module fa_dataflow (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-2:0] sh_s;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_next;

    fa_dataflow u_fa (
        .s  (fa_s),
        .co (fa_co),
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .ci (carry)
    );

    // New sum bit enters at the MSB; after WIDTH steps the LSB has arrived at bit 0.
    assign sum_next = {fa_s, sh_s};
    assign busy     = (state != IDLE);

    // NOTE: all state below is sequential and updated with non-blocking assignments,
    // so every register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            co    <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= ci;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_s  <= sum_next[WIDTH-1:1];
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        s     <= sum_next;
                        co    <= fa_co;
                        done  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB on this step
                        ovf   <= carry ^ fa_co;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard queues per instance (WIDTH=8 and WIDTH=4),
// per-scenario tasks with inline timing checks, one summary line at the end.

module tb_serial_adder;
    localparam int W  = 8;
    localparam int W4 = 4;

    typedef struct {
        logic [W:0] sum;
        logic       ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, ci, busy, done, co, ovf;
    logic [W-1:0] a, b, s;
    logic          start4, ci4, busy4, done4, co4, ovf4;
    logic [W4-1:0] a4, b4, s4;

    int   total = 0;
    int   bad   = 0;
    exp_t q8[$];
    logic [W4:0] q4[$];
    exp_t e8;
    logic [W4:0] e4;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .s     (s),
        .co    (co)
    );

    serial_adder #(.WIDTH(W4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .ci    (ci4),
        .busy  (busy4),
        .done  (done4),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf4),
`endif
        .s     (s4),
        .co    (co4)
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf4 = 1'b0;
`endif

    function automatic exp_t model8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t r;
        r.sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        r.ovf = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
        return r;
    endfunction

    // Scoreboard for the WIDTH=8 instance
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            total++;
            if (q8.size() == 0) begin
                bad++;
                $display("FAIL w8_unexpected_done got s=%h co=%b expected no done", s, co);
            end else begin
                e8 = q8.pop_front();
                if ({co, s} !== e8.sum) begin
                    bad++;
                    $display("FAIL w8_result got %h expected %h", {co, s}, e8.sum);
                end
`ifdef SERIAL_ADDER_OVF_EN
                total++;
                if (ovf !== e8.ovf) begin
                    bad++;
                    $display("FAIL w8_ovf got %b expected %b", ovf, e8.ovf);
                end
`endif
            end
        end
    end

    // Scoreboard for the WIDTH=4 instance
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done4 === 1'b1) begin
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL w4_unexpected_done got s=%h co=%b expected no done", s4, co4);
            end else begin
                e4 = q4.pop_front();
                if ({co4, s4} !== e4) begin
                    bad++;
                    $display("FAIL w4_result got %h expected %h", {co4, s4}, e4);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0; a  = '0; b  = '0; ci  = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
        #12;
        total++;
        if ({busy, done, s, co, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_w8 got %b expected 0", {busy, done, s, co, ovf});
        end
        total++;
        if ({busy4, done4, s4, co4, ovf4} !== '0) begin
            bad++;
            $display("FAIL reset_w4 got %b expected 0", {busy4, done4, s4, co4, ovf4});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full operation on the 8-bit instance with busy/done checked at every edge.
    task automatic run8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(posedge clk); #1;
        a = x; b = y; ci = c; start = 1'b1;
        q8.push_back(model8(x, y, c));
        @(posedge clk); #1;
        start = 1'b0;
        a = ~x; b = ~y; ci = ~c;
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL e0_busy_done got %b expected 10", {busy, done});
        end
        for (int k = 1; k <= W; k++) begin
            @(posedge clk); #1;
            total++;
            if ({busy, done} !== ((k == W) ? 2'b11 : 2'b10)) begin
                bad++;
                $display("FAIL run_busy_done k=%0d got %b expected %b", k, {busy, done},
                         (k == W) ? 2'b11 : 2'b10);
            end
        end
        @(posedge clk); #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL post_busy_done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        run8(8'h5A, 8'h3C, 1'b0);
    endtask

    task automatic test_boundary();
        run8(8'hFF, 8'h00, 1'b1);
        run8(8'h7F, 8'h01, 1'b0);
    endtask

    task automatic test_start_ignored();
        @(posedge clk); #1;
        a = 8'h12; b = 8'h34; ci = 1'b0; start = 1'b1;
        q8.push_back(model8(8'h12, 8'h34, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= W + 6; k++) begin
            if (k == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; ci = 1'b1;
            end
            @(posedge clk); #1;
            if (k == 3) start = 1'b0;
            total++;
            if (done !== (k == W)) begin
                bad++;
                $display("FAIL ignored_start_done k=%0d got %b expected %b", k, done, k == W);
            end
            if (k > W) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL ignored_start_no_rerun k=%0d got busy=%b expected 0", k, busy);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        a = 8'hAA; b = 8'h55; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, s, co, ovf} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs got %b expected 0", {busy, done, s, co, ovf});
        end
        #4;
        rst_n = 1'b1;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk); #1;
            total++;
            if ({busy, done} !== 2'b00) begin
                bad++;
                $display("FAIL mid_reset_quiet k=%0d got %b expected 00", k, {busy, done});
            end
        end
        run8(8'h01, 8'h01, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y;
        logic         c;
        @(posedge clk); #1;
        start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            a = x; b = y; ci = c;
            if (n % 10 == 0) q8.push_back(model8(x, y, c));
            @(posedge clk); #1;
            total++;
            if ({busy, done} !== {(n % 10) <= 8, (n % 10) == 8}) begin
                bad++;
                $display("FAIL b2b_busy_done n=%0d got %b expected %b", n, {busy, done},
                         {(n % 10) <= 8, (n % 10) == 8});
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (q8.size() != 0) begin
            bad++;
            $display("FAIL b2b_drained got %0d pending expected 0", q8.size());
        end
    endtask

    task automatic test_exhaustive();
        logic [2*W4:0] v;
        for (int i = 0; i < 512; i++) begin
            v = (2*W4+1)'(i);
            @(posedge clk); #1;
            ci4 = v[2*W4]; a4 = v[2*W4-1:W4]; b4 = v[W4-1:0]; start4 = 1'b1;
            q4.push_back({1'b0, v[2*W4-1:W4]} + {1'b0, v[W4-1:0]} + {{W4{1'b0}}, v[2*W4]});
            @(posedge clk); #1;
            start4 = 1'b0;
            repeat (W4) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (q4.size() != 0) begin
            bad++;
            $display("FAIL w4_drained got %0d pending expected 0", q4.size());
        end
        total++;
        if (q8.size() != 0) begin
            bad++;
            $display("FAIL w8_drained got %0d pending expected 0", q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
